// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: stage 1 barrel shifter, stage 2 data-processing ops + NZCV.
// Define RRX_EN to make ROR #0 perform rotate-right-extended through the C flag.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = 8,
  parameter int REGW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [SHW-1:0]   shAmt,
  input  logic [1:0]       shType,
  input  logic [3:0]       opcode,
  input  logic             setFlags,
  input  logic [REGW-1:0]  dstIn,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] result,
  output logic             wrEn,
  output logic [REGW-1:0]  dstOut,
  output logic [3:0]       flags
);

  typedef enum logic [3:0] {
    OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
    OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
    OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
    OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00, SH_LSR = 2'b01, SH_ASR = 2'b10, SH_ROR = 2'b11
  } shift_e;

  localparam logic [31:0] WU = WIDTH;

  logic s2Adv, s1Adv;

  logic             s1Valid;
  logic [WIDTH-1:0] s1A;
  logic [WIDTH-1:0] s1Val;
  logic             s1C;
  logic             s1CV;
  opcode_e          s1Op;
  logic             s1S;
  logic [REGW-1:0]  s1Dst;
`ifdef RRX_EN
  logic             s1Rrx;
  logic             shRrx;
`endif

  assign s2Adv   = !outValid || outReady;
  assign s1Adv   = s2Adv;
  assign inReady = !s1Valid || s1Adv;

  // ---------------- stage 1: barrel shifter ----------------
  logic [31:0]        nExt;
  logic [31:0]        rorAmt;
  logic [WIDTH:0]     lslT;
  logic [WIDTH:0]     lsrT;
  logic signed [WIDTH:0] asrT;
  logic [WIDTH-1:0]   rorT;
  logic [WIDTH-1:0]   shVal;
  logic               shC;
  logic               shCV;

  assign nExt   = 32'(shAmt);
  assign rorAmt = nExt % WU;
  // Extra guard bit catches the last bit shifted out; out-of-range amounts naturally give zero.
  assign lslT   = {1'b0, opB} << nExt;
  assign lsrT   = {opB, 1'b0} >> nExt;
  assign asrT   = $signed({opB, 1'b0}) >>> nExt;
  assign rorT   = (opB >> rorAmt) | (opB << (WU - rorAmt));

  always_comb begin
    shVal = opB;
    shC   = 1'b0;
    shCV  = (nExt != '0);
`ifdef RRX_EN
    shRrx = 1'b0;
`endif
    case (shift_e'(shType))
      SH_LSL: begin
        shVal = lslT[WIDTH-1:0];
        shC   = lslT[WIDTH];
      end
      SH_LSR: begin
        shVal = lsrT[WIDTH:1];
        shC   = lsrT[0];
      end
      SH_ASR: begin
        shVal = asrT[WIDTH:1];
        shC   = asrT[0];
      end
      SH_ROR: begin
        shVal = rorT;
        shC   = rorT[WIDTH-1];
`ifdef RRX_EN
        if (nExt == '0) begin
          shVal = opB;
          shC   = opB[0];
          shCV  = 1'b1;
          shRrx = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  // ---------------- stage 2: ALU and flags ----------------
  logic [WIDTH-1:0] bVal;
  logic [WIDTH-1:0] addX, addY;
  logic             addCin;
  logic [WIDTH:0]   sum;
  logic             isArith;
  logic [WIDTH-1:0] aluRes;
  logic [3:0]       nextFlags;
  logic             nextWrEn;

  always_comb begin
    bVal = s1Val;
`ifdef RRX_EN
    // RRX needs the C flag as the op enters this stage, so the rotate is completed here.
    if (s1Rrx) bVal = {flags[1], s1Val[WIDTH-1:1]};
`endif
    addX    = s1A;
    addY    = bVal;
    addCin  = 1'b0;
    isArith = 1'b1;
    aluRes  = '0;
    case (s1Op)
      OP_SUB, OP_CMP: begin addX = s1A;  addY = ~bVal; addCin = 1'b1;     end
      OP_RSB:         begin addX = bVal; addY = ~s1A;  addCin = 1'b1;     end
      OP_ADD, OP_CMN: begin addX = s1A;  addY = bVal;  addCin = 1'b0;     end
      OP_ADC:         begin addX = s1A;  addY = bVal;  addCin = flags[1]; end
      OP_SBC:         begin addX = s1A;  addY = ~bVal; addCin = flags[1]; end
      OP_RSC:         begin addX = bVal; addY = ~s1A;  addCin = flags[1]; end
      default:        isArith = 1'b0;
    endcase
    sum = {1'b0, addX} + {1'b0, addY} + {{WIDTH{1'b0}}, addCin};
    if (isArith) begin
      aluRes = sum[WIDTH-1:0];
    end else begin
      case (s1Op)
        OP_AND, OP_TST: aluRes = s1A & bVal;
        OP_EOR, OP_TEQ: aluRes = s1A ^ bVal;
        OP_ORR:         aluRes = s1A | bVal;
        OP_MOV:         aluRes = bVal;
        OP_BIC:         aluRes = s1A & ~bVal;
        OP_MVN:         aluRes = ~bVal;
        default:        aluRes = '0;
      endcase
    end

    nextFlags    = flags;
    nextFlags[3] = aluRes[WIDTH-1];
    nextFlags[2] = (aluRes == '0);
    if (isArith) begin
      nextFlags[1] = sum[WIDTH];
      nextFlags[0] = (addX[WIDTH-1] == addY[WIDTH-1]) && (sum[WIDTH-1] != addX[WIDTH-1]);
    end else if (s1CV) begin
      nextFlags[1] = s1C;
    end

    nextWrEn = !(s1Op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN});
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      outValid <= 1'b0;
      result   <= '0;
      wrEn     <= 1'b0;
      dstOut   <= '0;
      flags    <= '0;
    end else if (s2Adv) begin
      outValid <= s1Valid;
      if (s1Valid) begin
        result <= aluRes;
        wrEn   <= nextWrEn;
        dstOut <= s1Dst;
        if (s1S) flags <= nextFlags;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1Valid <= 1'b0;
      s1A     <= '0;
      s1Val   <= '0;
      s1C     <= 1'b0;
      s1CV    <= 1'b0;
      s1Op    <= OP_AND;
      s1S     <= 1'b0;
      s1Dst   <= '0;
`ifdef RRX_EN
      s1Rrx   <= 1'b0;
`endif
    end else if (inReady) begin
      s1Valid <= inValid;
      if (inValid) begin
        s1A   <= opA;
        s1Val <= shVal;
        s1C   <= shC;
        s1CV  <= shCV;
        s1Op  <= opcode_e'(opcode);
        s1S   <= setFlags;
        s1Dst <= dstIn;
`ifdef RRX_EN
        s1Rrx <= shRrx;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: arithmetic reference model predicts each op at acceptance,
// a negedge monitor pops and compares whenever an output transfer happens.
module tb_alu_pipe;
  localparam int W    = 32;
  localparam int SHW  = 8;
  localparam int REGW = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            inValid = 1'b0;
  logic            inReady;
  logic [W-1:0]    opA = '0, opB = '0;
  logic [SHW-1:0]  shAmt = '0;
  logic [1:0]      shType = '0;
  logic [3:0]      opcode = '0;
  logic            setFlags = 1'b0;
  logic [REGW-1:0] dstIn = '0;
  logic            outValid;
  logic            outReady = 1'b1;
  logic [W-1:0]    result;
  logic            wrEn;
  logic [REGW-1:0] dstOut;
  logic [3:0]      flags;

  alu_pipe #(.WIDTH(W), .SHW(SHW), .REGW(REGW)) dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
    .opA(opA), .opB(opB), .shAmt(shAmt), .shType(shType), .opcode(opcode),
    .setFlags(setFlags), .dstIn(dstIn), .outValid(outValid), .outReady(outReady),
    .result(result), .wrEn(wrEn), .dstOut(dstOut), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]    res;
    logic            wr;
    logic [REGW-1:0] dst;
    logic [3:0]      fl;
  } exp_t;

  exp_t        sb[$];
  logic [3:0]  mFlags = '0;
  int unsigned nChecks = 0;
  int unsigned nFail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    nChecks++;
    if (act !== req) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: shifter and ALU from the architectural rules, using 64-bit integer arithmetic.
  task automatic predict(input logic [W-1:0] a, input logic [W-1:0] b, input logic [SHW-1:0] sa,
                         input logic [1:0] st, input logic [3:0] opc, input logic s,
                         input logic [REGW-1:0] d);
    int unsigned n, r;
    logic [W-1:0] v, res;
    logic sc, scv, c, cOut, vOut, arith, isSub;
    logic [W-1:0] x, y;
    longint ux, uy, sx, sy, ci, sr, full;
    exp_t e;
    n = 32'(sa);
    c = mFlags[1];
    v = b; sc = 1'b0; scv = (n != 0);
    if (n == 0) begin
      v = b;
`ifdef RRX_EN
      if (st == 2'd3) begin v = {c, b[W-1:1]}; sc = b[0]; scv = 1'b1; end
`endif
    end else begin
      case (st)
        2'd0: if (n < W) begin v = b << n; sc = b[W-n]; end
              else if (n == W) begin v = '0; sc = b[0]; end
              else begin v = '0; sc = 1'b0; end
        2'd1: if (n < W) begin v = b >> n; sc = b[n-1]; end
              else if (n == W) begin v = '0; sc = b[W-1]; end
              else begin v = '0; sc = 1'b0; end
        2'd2: if (n < W) begin
                v = b >> n;
                if (b[W-1]) v = v | ~({W{1'b1}} >> n);
                sc = b[n-1];
              end else begin v = {W{b[W-1]}}; sc = b[W-1]; end
        default: begin
          r = n % W;
          if (r == 0) begin v = b; sc = b[W-1]; end
          else begin v = (b >> r) | (b << (W - r)); sc = v[W-1]; end
        end
      endcase
    end

    arith = 1'b1; isSub = 1'b0; x = a; y = v; ci = 0; res = '0;
    case (opc)
      4'h2, 4'hA: begin isSub = 1'b1; x = a; y = v; ci = 1; end
      4'h3:       begin isSub = 1'b1; x = v; y = a; ci = 1; end
      4'h4, 4'hB: begin x = a; y = v; ci = 0; end
      4'h5:       begin x = a; y = v; ci = longint'(c); end
      4'h6:       begin isSub = 1'b1; x = a; y = v; ci = longint'(c); end
      4'h7:       begin isSub = 1'b1; x = v; y = a; ci = longint'(c); end
      default:    arith = 1'b0;
    endcase
    ux = longint'(x); uy = longint'(y);
    sx = longint'($signed(x)); sy = longint'($signed(y));
    cOut = 1'b0; vOut = 1'b0;
    if (arith) begin
      if (!isSub) begin
        full = ux + uy + ci;
        cOut = (full > 64'sh0_FFFF_FFFF);
        sr   = sx + sy + ci;
      end else begin
        full = ux - uy - (1 - ci);
        cOut = (ux >= uy + (1 - ci));
        sr   = sx - sy - (1 - ci);
      end
      res  = full[W-1:0];
      vOut = (sr > 64'sh7FFF_FFFF) || (sr < -64'sh8000_0000);
    end else begin
      case (opc)
        4'h0, 4'h8: res = a & v;
        4'h1, 4'h9: res = a ^ v;
        4'hC:       res = a | v;
        4'hD:       res = v;
        4'hE:       res = a & ~v;
        default:    res = ~v;
      endcase
    end

    e.res = res;
    e.wr  = !(opc >= 4'h8 && opc <= 4'hB);
    e.dst = d;
    e.fl  = mFlags;
    if (s) begin
      e.fl[3] = res[W-1];
      e.fl[2] = (res == '0);
      if (arith) begin e.fl[1] = cOut; e.fl[0] = vOut; end
      else if (scv) e.fl[1] = sc;
    end
    mFlags = e.fl;
    sb.push_back(e);
  endtask

  // Monitor: compares on every transfer; also checks outputs hold while stalled.
  exp_t held;
  bit   holding = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      holding = 1'b0;
    end else begin
      if (holding && outValid)
        check("stall_hold", 64'({result, wrEn, dstOut, flags}), 64'(held));
      holding = 1'b0;
      if (outValid && outReady) begin
        if (sb.size() == 0) begin
          nChecks++;
          nFail++;
          $display("FAIL unexpected_out: got result 0x%0h dst %0d, expected no output", result, dstOut);
        end else begin
          e = sb.pop_front();
          check("result", 64'(result), 64'(e.res));
          check("wrEn",   64'(wrEn),   64'(e.wr));
          check("dstOut", 64'(dstOut), 64'(e.dst));
          check("flags",  64'(flags),  64'(e.fl));
        end
      end else if (outValid) begin
        holding = 1'b1;
        held    = {result, wrEn, dstOut, flags};
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [SHW-1:0] sa,
                       input logic [1:0] st, input logic [3:0] opc, input logic s,
                       input logic [REGW-1:0] d, input bit rnd);
    int unsigned waitCyc;
    waitCyc = 0;
    opA = a; opB = b; shAmt = sa; shType = st; opcode = opc; setFlags = s; dstIn = d;
    inValid = 1'b1;
    forever begin
      @(negedge clk);
      if (inReady) begin
        predict(a, b, sa, st, opc, s, d);
        break;
      end
      waitCyc++;
      if (waitCyc > 40) begin
        nChecks++;
        nFail++;
        $display("FAIL accept_timeout: inReady stayed 0, expected 1 within 40 cycles");
        break;
      end
      @(posedge clk); #1;
      if (rnd) outReady = ($urandom_range(3) != 0);
    end
    @(posedge clk); #1;
    inValid = 1'b0;
    if (rnd) outReady = ($urandom_range(3) != 0);
  endtask

  task automatic drain();
    int unsigned cyc;
    cyc = 0;
    outReady = 1'b1;
    while (sb.size() != 0 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (sb.size() != 0) begin
      nChecks++;
      nFail++;
      $display("FAIL drain_timeout: %0d ops outstanding, expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] specials [6];
    logic [SHW-1:0] amts [6];
    specials[0] = 32'h0000_0000; specials[1] = 32'hFFFF_FFFF; specials[2] = 32'h8000_0000;
    specials[3] = 32'h7FFF_FFFF; specials[4] = 32'h0000_0001; specials[5] = 32'h8000_0001;
    amts[0] = 8'd0; amts[1] = 8'd1; amts[2] = 8'd31; amts[3] = 8'd32; amts[4] = 8'd33; amts[5] = 8'd255;

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outValid", 64'(outValid), 64'(0));
    check("rst_inReady",  64'(inReady),  64'(1));
    check("rst_result",   64'(result),   64'(0));
    check("rst_wrEn",     64'(wrEn),     64'(0));
    check("rst_dstOut",   64'(dstOut),   64'(0));
    check("rst_flags",    64'(flags),    64'(0));
    reset = 1'b1;
    mFlags = '0;
    @(posedge clk); #1;

    // Directed: overflow, flag chaining, compare, shifter boundary, ROR #0
    issue(32'h7FFF_FFFF, 32'h1, 8'd0, 2'd0, 4'h4, 1'b1, 4'd1, 1'b0);
    issue(32'hFFFF_FFFF, 32'h1, 8'd0, 2'd0, 4'h4, 1'b1, 4'd2, 1'b0);
    issue(32'h5,         32'h0, 8'd0, 2'd0, 4'h5, 1'b0, 4'd3, 1'b0);
    issue(32'h3,         32'h3, 8'd0, 2'd0, 4'hA, 1'b1, 4'd4, 1'b0);
    issue(32'h0, 32'h8000_0001, 8'd32, 2'd1, 4'hD, 1'b1, 4'd5, 1'b0);
    issue(32'h0, 32'h0000_0003, 8'd0,  2'd3, 4'hD, 1'b1, 4'd6, 1'b0);
    drain();

    // Shifter boundaries: every type against amounts around WIDTH
    for (int t = 0; t < 4; t++)
      for (int k = 0; k < 6; k++)
        issue(32'h0, 32'h8000_0001, amts[k], 2'(t), 4'hD, 1'b1, 4'(k), 1'b0);
    drain();

    // Stall: both stages fill, third op must wait
    outReady = 1'b0;
    issue(32'h10, 32'h1, 8'd0, 2'd0, 4'h4, 1'b1, 4'd7, 1'b0);
    issue(32'h20, 32'h2, 8'd0, 2'd0, 4'h2, 1'b1, 4'd8, 1'b0);
    opA = 32'h30; opB = 32'h3; shAmt = '0; shType = '0; opcode = 4'hC; setFlags = 1'b1;
    dstIn = 4'd9; inValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_inReady", 64'(inReady), 64'(0));
      check("stall_outValid", 64'(outValid), 64'(1));
    end
    @(posedge clk); #1;
    outReady = 1'b1;
    issue(32'h30, 32'h3, 8'd0, 2'd0, 4'hC, 1'b1, 4'd9, 1'b0);
    drain();

    // Reset with two ops in flight
    outReady = 1'b0;
    issue(32'h0, 32'h8000_0000, 8'd0, 2'd0, 4'hD, 1'b1, 4'd10, 1'b0);
    issue(32'h1, 32'h1,         8'd0, 2'd0, 4'h4, 1'b1, 4'd11, 1'b0);
    reset = 1'b0;
    sb.delete();
    mFlags = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("midrst_outValid", 64'(outValid), 64'(0));
    check("midrst_flags",    64'(flags),    64'(0));
    check("midrst_inReady",  64'(inReady),  64'(1));
    outReady = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] a, b;
      logic [SHW-1:0] sa;
      a  = ($urandom_range(3) == 0) ? specials[$urandom_range(5)] : $urandom;
      b  = ($urandom_range(3) == 0) ? specials[$urandom_range(5)] : $urandom;
      sa = ($urandom_range(2) == 0) ? amts[$urandom_range(5)] : SHW'($urandom_range(40));
      issue(a, b, sa, 2'($urandom_range(3)), 4'($urandom_range(15)), 1'($urandom_range(1)),
            REGW'($urandom_range(15)), 1'b1);
      repeat ($urandom_range(2)) begin
        @(posedge clk); #1;
        outReady = ($urandom_range(3) != 0);
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
